// File: rtl/uart_rx_deser_param.sv
// UART RX deserializer: assembles start/data/parity/stop from centre-sampled bits
// and presents each clean word through a one-entry valid/ready output register.
module uart_rx_deser_param #(
    parameter int DATA_WIDTH = 8,
    parameter bit MSB_FIRST  = 1'b0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bit_vld,
    input  logic                  bit_in,
    input  logic                  cfg_par_en,
    input  logic                  cfg_par_typ,
    input  logic                  abort,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_vld,
    input  logic                  data_rdy,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  strt_err,
    output logic                  ovr_err,
    output logic                  busy
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] LAST_DATA = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    state_t                state_r, state_s;
    logic [DATA_WIDTH-1:0] shift_r, shift_s;
    logic [CW-1:0]         cnt_r, cnt_s;
    logic                  par_en_r, par_en_s;
    logic                  par_typ_r, par_typ_s;
    logic                  par_fail_r, par_fail_s;
    logic                  stp_fail_r, stp_fail_s;
    logic [DATA_WIDTH-1:0] p_data_r, p_data_s;
    logic                  data_vld_r, data_vld_s;
    logic                  par_err_r, par_err_s;
    logic                  stp_err_r, stp_err_s;
    logic                  strt_err_r, strt_err_s;
    logic                  ovr_err_r, ovr_err_s;
    logic                  busy_r;

    // Parity bit the transmitter should have sent for this word.
    function automatic logic expected_parity(input logic [DATA_WIDTH-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] cur, input logic b);
        if (MSB_FIRST) begin
            return {cur[DATA_WIDTH-2:0], b};
        end else begin
            return {b, cur[DATA_WIDTH-1:1]};
        end
    endfunction

    // Frame sequencer, commit and output-handshake next-state logic.
    always_comb begin
        state_s    = state_r;
        shift_s    = shift_r;
        cnt_s      = cnt_r;
        par_en_s   = par_en_r;
        par_typ_s  = par_typ_r;
        par_fail_s = par_fail_r;
        stp_fail_s = stp_fail_r;
        p_data_s   = p_data_r;
        par_err_s  = 1'b0;
        stp_err_s  = 1'b0;
        strt_err_s = 1'b0;
        ovr_err_s  = 1'b0;

        if (data_vld_r && data_rdy) begin
            data_vld_s = 1'b0;
        end else begin
            data_vld_s = data_vld_r;
        end

        if (abort) begin
            state_s    = ST_IDLE;
            cnt_s      = {CW{1'b0}};
            par_fail_s = 1'b0;
            stp_fail_s = 1'b0;
        end else if (bit_vld) begin
            case (state_r)
                ST_IDLE: begin
                    if (!bit_in) begin
                        state_s    = ST_DATA;
                        par_en_s   = cfg_par_en;
                        par_typ_s  = cfg_par_typ;
                        cnt_s      = {CW{1'b0}};
                        shift_s    = {DATA_WIDTH{1'b0}};
                        par_fail_s = 1'b0;
                        stp_fail_s = 1'b0;
                    end else begin
                        strt_err_s = 1'b1;
                    end
                end
                ST_DATA: begin
                    shift_s = shift_in(shift_r, bit_in);
                    if (cnt_r == LAST_DATA) begin
                        cnt_s   = {CW{1'b0}};
                        state_s = par_en_r ? ST_PARITY : ST_STOP;
                    end else begin
                        cnt_s = cnt_r + CW'(1'b1);
                    end
                end
                ST_PARITY: begin
                    par_fail_s = (bit_in != expected_parity(shift_r, par_typ_r));
                    state_s    = ST_STOP;
                end
                ST_STOP: begin
                    stp_fail_s = stp_fail_r | ~bit_in;
                    if (cnt_r == LAST_STOP) begin
                        state_s = ST_IDLE;
                        cnt_s   = {CW{1'b0}};
                        // Errored frames are reported but never overwrite the output register.
                        if (par_fail_r || stp_fail_s) begin
                            par_err_s = par_fail_r;
                            stp_err_s = stp_fail_s;
                        end else if (!data_vld_r || data_rdy) begin
                            p_data_s   = shift_r;
                            data_vld_s = 1'b1;
                        end else begin
                            ovr_err_s = 1'b1;
                        end
                    end else begin
                        cnt_s = cnt_r + CW'(1'b1);
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State, datapath and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            shift_r    <= {DATA_WIDTH{1'b0}};
            cnt_r      <= {CW{1'b0}};
            par_en_r   <= 1'b0;
            par_typ_r  <= 1'b0;
            par_fail_r <= 1'b0;
            stp_fail_r <= 1'b0;
            p_data_r   <= {DATA_WIDTH{1'b0}};
            data_vld_r <= 1'b0;
            par_err_r  <= 1'b0;
            stp_err_r  <= 1'b0;
            strt_err_r <= 1'b0;
            ovr_err_r  <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            shift_r    <= shift_s;
            cnt_r      <= cnt_s;
            par_en_r   <= par_en_s;
            par_typ_r  <= par_typ_s;
            par_fail_r <= par_fail_s;
            stp_fail_r <= stp_fail_s;
            p_data_r   <= p_data_s;
            data_vld_r <= data_vld_s;
            par_err_r  <= par_err_s;
            stp_err_r  <= stp_err_s;
            strt_err_r <= strt_err_s;
            ovr_err_r  <= ovr_err_s;
            busy_r     <= (state_s != ST_IDLE);
        end
    end

    assign p_data   = p_data_r;
    assign data_vld = data_vld_r;
    assign par_err  = par_err_r;
    assign stp_err  = stp_err_r;
    assign strt_err = strt_err_r;
    assign ovr_err  = ovr_err_r;
    assign busy     = busy_r;

endmodule

// File: tb/tb_uart_rx_deser_param.sv
// Directed bench: a frame table for the 8-bit LSB-first instance plus hand sequences
// for abort, false start, handshake and a 7-bit MSB-first two-stop-bit instance.
module tb_uart_rx_deser_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst8, rst7, bv8, bv7, bit_in, cfg_par_en, cfg_par_typ, abort, data_rdy;
    logic [7:0] p8;
    logic [6:0] p7;
    logic vld8, pe8, se8, te8, oe8, busy8;
    logic vld7, pe7, se7, te7, oe7, busy7;

    int checks = 0;
    int errors = 0;
    int gap = 0;

    uart_rx_deser_param #(.DATA_WIDTH(8), .MSB_FIRST(1'b0), .STOP_BITS(1)) dut8 (
        .clk(clk), .rst(rst8), .bit_vld(bv8), .bit_in(bit_in),
        .cfg_par_en(cfg_par_en), .cfg_par_typ(cfg_par_typ), .abort(abort),
        .p_data(p8), .data_vld(vld8), .data_rdy(data_rdy),
        .par_err(pe8), .stp_err(se8), .strt_err(te8), .ovr_err(oe8), .busy(busy8)
    );

    uart_rx_deser_param #(.DATA_WIDTH(7), .MSB_FIRST(1'b1), .STOP_BITS(2)) dut7 (
        .clk(clk), .rst(rst7), .bit_vld(bv7), .bit_in(bit_in),
        .cfg_par_en(cfg_par_en), .cfg_par_typ(cfg_par_typ), .abort(abort),
        .p_data(p7), .data_vld(vld7), .data_rdy(data_rdy),
        .par_err(pe7), .stp_err(se7), .strt_err(te7), .ovr_err(oe7), .busy(busy7)
    );

    typedef struct {
        logic [7:0] d;
        logic       pe, pt, pb, stp, rdy, rl;
        logic [7:0] exp_data;
        logic       exp_vld, exp_par, exp_stp, exp_ovr;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b, input logic which);
        repeat (gap) @(posedge clk);
        @(negedge clk);
        bit_in = b;
        if (which) bv7 = 1'b1;
        else bv8 = 1'b1;
        @(posedge clk);
        #1;
        bv8 = 1'b0;
        bv7 = 1'b0;
    endtask

    // Returns one time unit after the edge that samples the last stop bit.
    task automatic send_frame(input logic which, input logic [8:0] d, input int dw, input logic msb,
                              input logic pe, input logic pt, input logic pb,
                              input logic [1:0] stops, input int nstop, input logic rdy, input logic rl);
        cfg_par_en  = pe;
        cfg_par_typ = pt;
        data_rdy    = rdy;
        send_bit(1'b0, which);
        cfg_par_en  = ~pe;
        cfg_par_typ = ~pt;
        for (int i = 0; i < dw; i++) begin
            send_bit(msb ? d[dw-1-i] : d[i], which);
        end
        if (pe) send_bit(pb, which);
        for (int i = 0; i < nstop; i++) begin
            if (i == nstop - 1) data_rdy = rl;
            send_bit(stops[i], which);
        end
        data_rdy = 1'b0;
    endtask

    initial begin
        //            d      pe    pt    pb    stp   rdy   rl    data   vld   par   stp   ovr
        vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{8'h07, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h07, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{8'h07, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h07, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h07, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[9] = '{8'h80, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0};

        rst8 = 1'b1; rst7 = 1'b1; bv8 = 1'b0; bv7 = 1'b0; bit_in = 1'b1;
        cfg_par_en = 1'b0; cfg_par_typ = 1'b0; abort = 1'b0; data_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst8 = 1'b0; rst7 = 1'b0;
        chk("reset_p_data", 32'(p8), 32'h0);
        chk("reset_vld", 32'(vld8), 32'h0);
        chk("reset_busy", 32'(busy8), 32'h0);
        chk("reset_errs", 32'({pe8, se8, te8, oe8}), 32'h0);

        for (int i = 0; i < 10; i++) begin
            send_frame(1'b0, {1'b0, vecs[i].d}, 8, 1'b0, vecs[i].pe, vecs[i].pt, vecs[i].pb,
                       {1'b1, vecs[i].stp}, 1, vecs[i].rdy, vecs[i].rl);
            chk($sformatf("v%0d_p_data", i), 32'(p8), 32'(vecs[i].exp_data));
            chk($sformatf("v%0d_vld", i), 32'(vld8), 32'(vecs[i].exp_vld));
            chk($sformatf("v%0d_par_err", i), 32'(pe8), 32'(vecs[i].exp_par));
            chk($sformatf("v%0d_stp_err", i), 32'(se8), 32'(vecs[i].exp_stp));
            chk($sformatf("v%0d_ovr_err", i), 32'(oe8), 32'(vecs[i].exp_ovr));
            chk($sformatf("v%0d_busy", i), 32'(busy8), 32'h0);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_pulse_end", i), 32'({pe8, se8, te8, oe8}), 32'h0);
        end

        // Consumer accepts the pending word.
        @(negedge clk); data_rdy = 1'b1;
        @(posedge clk); #1; data_rdy = 1'b0;
        chk("accept_vld", 32'(vld8), 32'h0);
        chk("accept_p_data", 32'(p8), 32'h80);

        send_bit(1'b1, 1'b0);
        chk("false_start", 32'(te8), 32'h1);
        chk("false_start_busy", 32'(busy8), 32'h0);

        // Abort three bits into a frame, asserted together with a strobe.
        cfg_par_en = 1'b0;
        send_bit(1'b0, 1'b0);
        chk("abort_pre_busy", 32'(busy8), 32'h1);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
        @(negedge clk); abort = 1'b1; bv8 = 1'b1; bit_in = 1'b0;
        @(posedge clk); #1; abort = 1'b0; bv8 = 1'b0;
        chk("abort_busy", 32'(busy8), 32'h0);
        chk("abort_errs", 32'({pe8, se8, te8, oe8}), 32'h0);
        chk("abort_vld", 32'(vld8), 32'h0);
        gap = 2;
        send_frame(1'b0, 9'h05A, 8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1, 1'b0, 1'b0);
        gap = 0;
        chk("after_abort_p_data", 32'(p8), 32'h5A);
        chk("after_abort_vld", 32'(vld8), 32'h1);
        chk("after_abort_errs", 32'({pe8, se8, te8, oe8}), 32'h0);

        // 7-bit MSB-first instance with two stop bits.
        send_frame(1'b1, 9'h041, 7, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2, 1'b0, 1'b0);
        chk("w7_stp_err", 32'(se7), 32'h1);
        chk("w7_err_vld", 32'(vld7), 32'h0);
        chk("w7_err_p_data", 32'(p7), 32'h0);
        send_frame(1'b1, 9'h00B, 7, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 2, 1'b0, 1'b0);
        chk("w7_p_data", 32'(p7), 32'h0B);
        chk("w7_vld", 32'(vld7), 32'h1);
        chk("w7_clean_errs", 32'({pe7, se7, te7, oe7}), 32'h0);
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b1);
        chk("w7_mid_busy", 32'(busy7), 32'h1);
        @(negedge clk); rst7 = 1'b1;
        @(posedge clk); #1; rst7 = 1'b0;
        chk("w7_rst_p_data", 32'(p7), 32'h0);
        chk("w7_rst_vld", 32'(vld7), 32'h0);
        chk("w7_rst_busy", 32'(busy7), 32'h0);
        chk("w7_rst_errs", 32'({pe7, se7, te7, oe7}), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
